// File: rtl/wb_stage_if.sv
// Bundle of MEM-side capture inputs and register-file write outputs of the
// write-back stage; the stage itself connects through the slave modport.
interface wb_stage_if;
  logic        en;
  logic        clr;
  logic        RegWrite_M;
  logic [4:0]  WA_M;
  logic [1:0]  WBSel_M;
  logic [2:0]  LoadType_M;
  logic [31:0] ALUResult_M;
  logic [31:0] MemData_M;
  logic [31:0] PC_M;

  logic [4:0]  WA;
  logic [31:0] WD;
  logic        RegWrite;
  logic [31:0] PC;
  logic        AdEL;

  modport master (
    output en, clr, RegWrite_M, WA_M, WBSel_M, LoadType_M,
           ALUResult_M, MemData_M, PC_M,
    input  WA, WD, RegWrite, PC, AdEL
  );

  modport slave (
    input  en, clr, RegWrite_M, WA_M, WBSel_M, LoadType_M,
           ALUResult_M, MemData_M, PC_M,
    output WA, WD, RegWrite, PC, AdEL
  );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register plus write-back mux: load extraction, PC+8 link
// value and misaligned-load detection, all from registered fields only.
module wb_stage #(
  parameter logic [31:0] RESET_PC = 32'h00003000
) (
  input  logic       clk,
  input  logic       reset,
  wb_stage_if.slave  wb
);

  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  logic        regwrite_q, regwrite_d;
  logic [4:0]  wa_q,       wa_d;
  logic [1:0]  wbsel_q,    wbsel_d;
  logic [2:0]  loadtype_q, loadtype_d;
  logic [31:0] alures_q,   alures_d;
  logic [31:0] memdata_q,  memdata_d;
  logic [31:0] pc_q,       pc_d;

  // A bubble captures the same NOP image that reset produces.
  always_comb begin
    regwrite_d = 1'b0;
    wa_d       = '0;
    wbsel_d    = '0;
    loadtype_d = '0;
    alures_d   = '0;
    memdata_d  = '0;
    pc_d       = RESET_PC;
    if (!wb.clr) begin
      regwrite_d = wb.RegWrite_M;
      wa_d       = wb.WA_M;
      wbsel_d    = wb.WBSel_M;
      loadtype_d = wb.LoadType_M;
      alures_d   = wb.ALUResult_M;
      memdata_d  = wb.MemData_M;
      pc_d       = wb.PC_M;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      wa_q       <= '0;
      wbsel_q    <= '0;
      loadtype_q <= '0;
      alures_q   <= '0;
      memdata_q  <= '0;
      pc_q       <= RESET_PC;
    end else if (wb.en) begin
      regwrite_q <= regwrite_d;
      wa_q       <= wa_d;
      wbsel_q    <= wbsel_d;
      loadtype_q <= loadtype_d;
      alures_q   <= alures_d;
      memdata_q  <= memdata_d;
      pc_q       <= pc_d;
    end
  end

  logic [1:0]  byte_off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic        is_half;
  logic        is_word;
  logic        adel;
  logic [31:0] wd;

  assign byte_off = alures_q[1:0];
  assign half_sel = alures_q[1] ? memdata_q[31:16] : memdata_q[15:0];
  assign is_half  = (loadtype_q == LT_LH) || (loadtype_q == LT_LHU);
  // Undefined load types fall back to word behaviour, including alignment.
  assign is_word  = !is_half && (loadtype_q != LT_LB) && (loadtype_q != LT_LBU);

  always_comb begin
    byte_sel = memdata_q[7:0];
    case (byte_off)
      2'd1:    byte_sel = memdata_q[15:8];
      2'd2:    byte_sel = memdata_q[23:16];
      2'd3:    byte_sel = memdata_q[31:24];
      default: byte_sel = memdata_q[7:0];
    endcase
  end

  always_comb begin
    load_data = memdata_q;
    case (loadtype_q)
      LT_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  load_data = {24'h000000, byte_sel};
      LT_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  load_data = {16'h0000, half_sel};
      default: load_data = memdata_q;
    endcase
  end

  assign adel = (wbsel_q == SEL_LOAD) &&
                ((is_word && (byte_off != 2'b00)) || (is_half && byte_off[0]));

  always_comb begin
    wd = alures_q;
    case (wbsel_q)
      SEL_LOAD: wd = load_data;
      SEL_LINK: wd = pc_q + 32'd8;
      default:  wd = alures_q;
    endcase
  end

  assign wb.WA       = wa_q;
  assign wb.WD       = wd;
  assign wb.PC       = pc_q;
  assign wb.AdEL     = adel;
  assign wb.RegWrite = regwrite_q && (wa_q != 5'd0) && !adel;

endmodule
